// File: rtl/match_seq.sv
// Multi-cycle byte-match sequencer: finds the lowest bit position in src2_i
// holding the pattern byte src1_i[PAT_W-1:0], stalling the pipeline meanwhile.
module match_seq #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PAT_W  = 8,
   parameter int unsigned POS_PC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              annul_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   output logic [DATA_W-1:0] result_o,
   output logic              ready_o,
   output logic              stallreq_o
);

   localparam int unsigned NPOS  = DATA_W - PAT_W + 1;
   localparam int unsigned IDX_W = $clog2(NPOS + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [PAT_W-1:0]  pat;
   logic [DATA_W-1:0] data;
   logic [IDX_W-1:0]  idx;

   logic              hit;
   logic [DATA_W-1:0] hit_pos;
   logic              last;
   logic              unused_src1;

   assign unused_src1 = ^src1_i[DATA_W-1:PAT_W];

   // Windows are picked by index instead of shifting the operand; the first hit wins.
   always_comb begin
      hit     = 1'b0;
      hit_pos = '0;
      for (int unsigned j = 0; j < POS_PC; j++) begin
         if (!hit && (data[(32'(idx) + j) +: PAT_W] == pat)) begin
            hit     = 1'b1;
            hit_pos = DATA_W'(32'(idx) + j);
         end
      end
      last = ((32'(idx) + POS_PC) == NPOS);
   end

   assign stallreq_o = (state == BUSY) || ((state == IDLE) && start_i && !annul_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pat      <= '0;
         data     <= '0;
         idx      <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && !annul_i) begin
                  pat   <= src1_i[PAT_W-1:0];
                  data  <= src2_i;
                  idx   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (annul_i) begin
                  state <= IDLE;
               end else if (hit) begin
                  result_o <= hit_pos;
                  ready_o  <= 1'b1;
                  state    <= DONE;
               end else if (last) begin
                  result_o <= '1;
                  ready_o  <= 1'b1;
                  state    <= DONE;
               end else begin
                  idx <= idx + IDX_W'(POS_PC);
               end
            end
            DONE: begin
               result_o <= '0;
               ready_o  <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
